// File: rtl/mc_controller_if.sv
// mc_controller_if: control bus between the multicycle MIPS controller and its datapath.
// Ports: op/funct/zero flow from datapath to controller; every select, enable,
// ALU control, zeroext, illegal pulse and the debug state flow back.
interface mc_controller_if;
    logic [5:0] op;
    logic [5:0] funct;
    logic       zero;
    logic       pcen;
    logic       memwrite;
    logic       irwrite;
    logic       regwrite;
    logic       iord;
    logic       memtoreg;
    logic       regdst;
    logic       alusrca;
    logic [1:0] alusrcb;
    logic [1:0] pcsrc;
    logic [2:0] alucontrol;
    logic       zeroext;
    logic       illegal;
    logic [3:0] state;
    modport master (
        input  op, funct, zero,
        output pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, zeroext, illegal, state
    );
    modport slave (
        output op, funct, zero,
        input  pcen, memwrite, irwrite, regwrite, iord, memtoreg, regdst,
               alusrca, alusrcb, pcsrc, alucontrol, zeroext, illegal, state
    );
endinterface

// File: rtl/mc_controller.sv
// mc_controller: Moore control FSM plus ALU decoder for the multicycle MIPS datapath.
// Ports: clk, reset (sync, active-high), bus (mc_controller_if.master) carrying
// op/funct/zero in and all datapath controls out. Macro MC_ORI_EN adds ori support.
module mc_controller (
    input  logic               clk,
    input  logic               reset,
    mc_controller_if.master    bus
);
    typedef enum logic [3:0] {
        FETCH   = 4'd0,
        DECODE  = 4'd1,
        MEMADR  = 4'd2,
        MEMRD   = 4'd3,
        MEMWB   = 4'd4,
        MEMWR   = 4'd5,
        RTYPEEX = 4'd6,
        RTYPEWB = 4'd7,
        BEQEX   = 4'd8,
        ADDIEX  = 4'd9,
        ADDIWB  = 4'd10,
        JEX     = 4'd11,
        ORIEX   = 4'd12,
        ORIWB   = 4'd13
    } state_t;

    state_t     st, nx, cur;
    logic       pcwrite, branch, memwrite, irwrite, regwrite, iord, memtoreg;
    logic       regdst, alusrca, zeroext, illegal;
    logic [1:0] alusrcb, pcsrc, aluop;
    logic [2:0] funct_ctl;

    always_ff @(posedge clk) begin
        st <= reset ? FETCH : nx;
    end

    // While reset is held the outputs decode as FETCH; enables are masked below.
    assign cur = reset ? FETCH : st;

    always_comb begin
        nx       = FETCH;
        pcwrite  = 1'b0;
        branch   = 1'b0;
        memwrite = 1'b0;
        irwrite  = 1'b0;
        regwrite = 1'b0;
        iord     = 1'b0;
        memtoreg = 1'b0;
        regdst   = 1'b0;
        alusrca  = 1'b0;
        alusrcb  = 2'b00;
        pcsrc    = 2'b00;
        aluop    = 2'b00;
        zeroext  = 1'b0;
        illegal  = 1'b0;
        case (cur)
            FETCH: begin
                alusrcb = 2'b01;
                irwrite = 1'b1;
                pcwrite = 1'b1;
                nx      = DECODE;
            end
            DECODE: begin
                alusrcb = 2'b11;
                case (bus.op)
                    6'b100011, 6'b101011: nx = MEMADR;
                    6'b000000:            nx = RTYPEEX;
                    6'b000100:            nx = BEQEX;
                    6'b001000:            nx = ADDIEX;
                    6'b000010:            nx = JEX;
`ifdef MC_ORI_EN
                    6'b001101:            nx = ORIEX;
`endif
                    default:              illegal = 1'b1;
                endcase
            end
            MEMADR: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nx      = bus.op == 6'b100011 ? MEMRD : MEMWR;
            end
            MEMRD: begin
                iord = 1'b1;
                nx   = MEMWB;
            end
            MEMWB: begin
                memtoreg = 1'b1;
                regwrite = 1'b1;
            end
            MEMWR: begin
                iord     = 1'b1;
                memwrite = 1'b1;
            end
            RTYPEEX: begin
                alusrca = 1'b1;
                aluop   = 2'b10;
                nx      = RTYPEWB;
            end
            RTYPEWB: begin
                regdst   = 1'b1;
                regwrite = 1'b1;
            end
            BEQEX: begin
                alusrca = 1'b1;
                aluop   = 2'b01;
                pcsrc   = 2'b01;
                branch  = 1'b1;
            end
            ADDIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                nx      = ADDIWB;
            end
            ADDIWB: regwrite = 1'b1;
            JEX: begin
                pcsrc   = 2'b10;
                pcwrite = 1'b1;
            end
`ifdef MC_ORI_EN
            ORIEX: begin
                alusrca = 1'b1;
                alusrcb = 2'b10;
                aluop   = 2'b11;
                zeroext = 1'b1;
                nx      = ORIWB;
            end
            ORIWB: begin
                regwrite = 1'b1;
                zeroext  = 1'b1;
            end
`endif
            default: nx = FETCH;
        endcase
    end

    // Unknown R-type funct codes fall back to add rather than trapping.
    assign funct_ctl = bus.funct == 6'b100010 ? 3'b110 :
                       bus.funct == 6'b100100 ? 3'b000 :
                       bus.funct == 6'b100101 ? 3'b001 :
                       bus.funct == 6'b101010 ? 3'b111 : 3'b010;

    assign bus.alucontrol = aluop == 2'b00 ? 3'b010 :
                            aluop == 2'b01 ? 3'b110 :
                            aluop == 2'b11 ? 3'b001 : funct_ctl;

    assign bus.pcen     = ~reset & (pcwrite | (branch & bus.zero));
    assign bus.memwrite = ~reset & memwrite;
    assign bus.irwrite  = ~reset & irwrite;
    assign bus.regwrite = ~reset & regwrite;
    assign bus.illegal  = ~reset & illegal;
    assign bus.iord     = iord;
    assign bus.memtoreg = memtoreg;
    assign bus.regdst   = regdst;
    assign bus.alusrca  = alusrca;
    assign bus.alusrcb  = alusrcb;
    assign bus.pcsrc    = pcsrc;
    assign bus.state    = st;
`ifdef MC_ORI_EN
    assign bus.zeroext  = zeroext;
`else
    assign bus.zeroext  = 1'b0;
`endif
endmodule

// File: tb/tb_mc_controller.sv
// tb_mc_controller: self-checking bench for mc_controller using a per-instruction
// path model (state walk from the instruction class) and per-state control table.
// Ports: none; drives mc_controller_if.
module tb_mc_controller;
    logic clk = 1'b0;
    logic reset;
    int   vectors = 0;
    int   miscompares = 0;
    int   p_n;
    int   p_s [0:5];

    always #5 clk = ~clk;

    mc_controller_if bus ();
    mc_controller dut (.clk(clk), .reset(reset), .bus(bus));

    function automatic logic is_legal(input logic [5:0] o);
        is_legal = o == 6'b100011 || o == 6'b101011 || o == 6'b000000 ||
                   o == 6'b000100 || o == 6'b001000 || o == 6'b000010;
`ifdef MC_ORI_EN
        if (o == 6'b001101) is_legal = 1'b1;
`endif
    endfunction

    // Sequence of states an instruction class visits, FETCH first.
    task automatic make_path(input logic [5:0] o);
        p_s[0] = 0;
        p_s[1] = 1;
        p_n = 2;
        case (o)
            6'b100011: begin p_s[2] = 2; p_s[3] = 3; p_s[4] = 4; p_n = 5; end
            6'b101011: begin p_s[2] = 2; p_s[3] = 5; p_n = 4; end
            6'b000000: begin p_s[2] = 6; p_s[3] = 7; p_n = 4; end
            6'b000100: begin p_s[2] = 8; p_n = 3; end
            6'b001000: begin p_s[2] = 9; p_s[3] = 10; p_n = 4; end
            6'b000010: begin p_s[2] = 11; p_n = 3; end
`ifdef MC_ORI_EN
            6'b001101: begin p_s[2] = 12; p_s[3] = 13; p_n = 4; end
`endif
            default: p_n = 2;
        endcase
    endtask

    function automatic logic [2:0] alu_ref(input logic [1:0] aop, input logic [5:0] f);
        if (aop == 2'b01) return 3'b110;
        if (aop == 2'b11) return 3'b001;
        if (aop == 2'b00) return 3'b010;
        case (f)
            6'b100010: return 3'b110;
            6'b100100: return 3'b000;
            6'b100101: return 3'b001;
            6'b101010: return 3'b111;
            default:   return 3'b010;
        endcase
    endfunction

    // {pcen,memwrite,irwrite,regwrite,iord,memtoreg,regdst,alusrca,alusrcb,pcsrc,alucontrol,zeroext,illegal}
    function automatic logic [16:0] exp_ctrl(input int st, input logic [5:0] o,
                                             input logic [5:0] f, input logic z, input logic rst);
        logic pcw = 0, br = 0, mw = 0, irw = 0, rw = 0, io = 0, m2r = 0, rd = 0, sa = 0, zx = 0, ill = 0;
        logic [1:0] sb = 0, ps = 0, aop = 0;
        case (rst ? 0 : st)
            0:  begin sb = 1; irw = 1; pcw = 1; end
            1:  begin sb = 3; ill = !is_legal(o); end
            2:  begin sa = 1; sb = 2; end
            3:  io = 1;
            4:  begin m2r = 1; rw = 1; end
            5:  begin io = 1; mw = 1; end
            6:  begin sa = 1; aop = 2; end
            7:  begin rd = 1; rw = 1; end
            8:  begin sa = 1; aop = 1; ps = 1; br = 1; end
            9:  begin sa = 1; sb = 2; end
            10: rw = 1;
            11: begin ps = 2; pcw = 1; end
            12: begin sa = 1; sb = 2; aop = 3; zx = 1; end
            13: begin rw = 1; zx = 1; end
            default: ;
        endcase
        return {~rst & (pcw | (br & z)), ~rst & mw, ~rst & irw, ~rst & rw, io, m2r, rd, sa,
                sb, ps, alu_ref(aop, f), zx, ~rst & ill};
    endfunction

    function automatic logic [16:0] obs_ctrl();
        return {bus.pcen, bus.memwrite, bus.irwrite, bus.regwrite, bus.iord, bus.memtoreg,
                bus.regdst, bus.alusrca, bus.alusrcb, bus.pcsrc, bus.alucontrol, bus.zeroext,
                bus.illegal};
    endfunction

    task automatic check_ctrl(input string tag, input int st);
        logic [16:0] o, e;
        o = obs_ctrl();
        e = exp_ctrl(st, bus.op, bus.funct, bus.zero, reset);
        vectors++;
        assert (o === e) else begin
            miscompares++;
            $error("FAIL ctrl %s op=%b st=%0d observed=%b expected=%b", tag, bus.op, st, o, e);
        end
    endtask

    task automatic check_state(input string tag, input int st);
        vectors++;
        assert (bus.state === 4'(st)) else begin
            miscompares++;
            $error("FAIL state %s op=%b observed=%0d expected=%0d", tag, bus.op, bus.state, st);
        end
    endtask

    // zmode 0/1 drives zero constant, 2 randomizes it every cycle.
    task automatic run(input string tag, input logic [5:0] o, input logic [5:0] f,
                       input int zmode, input int steps);
        make_path(o);
        if (steps > p_n) steps = p_n;
        for (int i = 0; i < steps; i++) begin
            bus.op = o;
            bus.funct = f;
            bus.zero = zmode == 2 ? 1'($urandom_range(0, 1)) : 1'(zmode);
            #1;
            check_state(tag, p_s[i]);
            check_ctrl(tag, p_s[i]);
            @(negedge clk);
        end
    endtask

    initial begin
        logic [5:0] ops [0:7];
        logic [5:0] functs [0:5];
        ops = '{6'b100011, 6'b101011, 6'b000000, 6'b000100, 6'b001000, 6'b000010, 6'b001101, 6'b111111};
        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010, 6'b111111};
        bus.op = 6'b0;
        bus.funct = 6'b0;
        bus.zero = 1'b0;
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        #1 check_ctrl("por", 0);
        reset = 1'b0;
        run("rtype_pre", 6'b000000, 6'b100000, 1, 2);
        for (int i = 0; i < 3; i++) begin
            reset = 1'b1;
            bus.zero = 1'b1;
            #1 check_ctrl("in_reset", 0);
            @(negedge clk);
        end
        reset = 1'b0;
        run("lw", 6'b100011, 6'b0, 2, 99);
        run("sw", 6'b101011, 6'b0, 2, 99);
        run("beq_z1", 6'b000100, 6'b0, 1, 99);
        run("beq_z0", 6'b000100, 6'b0, 0, 99);
        for (int i = 0; i < 6; i++) run("rtype", 6'b000000, functs[i], 2, 99);
        run("ori", 6'b001101, 6'b0, 2, 99);
        run("addi", 6'b001000, 6'b0, 2, 99);
        run("j", 6'b000010, 6'b0, 2, 99);
        for (int i = 0; i < 300; i++) begin
            logic [5:0] o;
            o = $urandom_range(0, 3) == 0 ? 6'($urandom) : ops[$urandom_range(0, 7)];
            run("rand", o, $urandom_range(0, 3) == 0 ? 6'($urandom) : functs[$urandom_range(0, 5)],
                2, 99);
        end
        run("final", 6'b000010, 6'b0, 0, 99);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
